// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// A WIDTH-bit binary value is captured on a start strobe and converted in
// WIDTH shift cycles. The result is presented as DIGITS packed BCD digits,
// along with an overflow flag for values that do not fit.
//
// Ports
//   i_clk    in   1          system clock, rising edge
//   i_rst    in   1          synchronous reset, active-high, dominates all inputs
//   i_start  in   1          conversion request, honoured in IDLE and DONE only
//   i_bin    in   WIDTH      binary operand, captured when i_start is accepted
//   o_busy   out  1          high while converting (SHIFT state)
//   o_done   out  1          one-cycle pulse; o_bcd/o_ovf valid from this cycle
//   o_bcd    out  4*DIGITS   packed BCD result, digit 0 (units) in bits [3:0]
//   o_ovf    out  1          result exceeded DIGITS digits; o_bcd is value mod 10^DIGITS
//
// Handshake: i_start is a request sampled on the rising edge while the block
// is idle or in its DONE cycle. Requests made during SHIFT are dropped, not
// queued. o_done is a single-cycle strobe. It carries no ready/ack, and the
// result stays on o_bcd/o_ovf until the next conversion completes.
//
// Internal FSM state is held in state_q (IDLE, SHIFT, DONE), which checkers
// can reach hierarchically.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]   work_q;
  logic            ovf_work_q;
  logic [BW-1:0]   bcd_q;
  logic            ovf_q;

  logic            accept;
  logic            finish;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   work_nx;
  logic            ovf_nx;

  // One double-dabble iteration. Each digit is corrected independently, and
  // no carry passes between digits. Because of this, the lower digits stay
  // exact even when the top digit overflows.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
    work_nx = {adj[BW-2:0], bin_q[WIDTH-1]};
    ovf_nx  = ovf_work_q | adj[BW-1];
  end

  // Next-state logic and control strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The counter still holds the iteration being done in this cycle.
        if (cnt_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_work_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bin_q      <= i_bin;
        work_q     <= '0;
        ovf_work_q <= 1'b0;
        cnt_q      <= CW'(WIDTH);
      end else if (state_q == SHIFT) begin
        bin_q      <= bin_q << 1;
        work_q     <= work_nx;
        ovf_work_q <= ovf_nx;
        cnt_q      <= cnt_q - CW'(1);
      end
      // Publish the final iteration's values directly. The result is then
      // valid in the DONE cycle itself.
      if (finish) begin
        bcd_q <= work_nx;
        ovf_q <= ovf_nx;
      end
    end
  end

  assign o_busy = (state_q == SHIFT);
  assign o_done = (state_q == DONE);
  assign o_bcd  = bcd_q;
  assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // default instance (WIDTH=8, DIGITS=3)
  logic        start1;
  logic [7:0]  bin1;
  logic        busy1, done1, ovf1;
  logic [11:0] bcd1;

  // narrow instance (WIDTH=8, DIGITS=2) for overflow cases
  logic        start2;
  logic [7:0]  bin2;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_bin(bin1),
    .o_busy(busy1), .o_done(done1), .o_bcd(bcd1), .o_ovf(ovf1)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_bin(bin2),
    .o_busy(busy2), .o_done(done2), .o_bcd(bcd2), .o_ovf(ovf2)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Starts one conversion on the selected instance and runs until o_done or
  // a 30-cycle budget. Returns what was seen; callers do the comparing.
  // lat is the cycle of o_done relative to the start cycle (-1 on timeout).
  task automatic convert(input bit sel, input logic [7:0] v,
                         output logic [11:0] bcd, output logic ovf,
                         output int lat, output int busy_cycles);
    logic d, b;
    lat = -1;
    busy_cycles = 0;
    bcd = '0;
    ovf = 1'b0;
    if (sel) begin start2 = 1'b1; bin2 = v; end
    else     begin start1 = 1'b1; bin1 = v; end
    for (int c = 1; c <= 30; c++) begin
      tick();
      start1 = 1'b0;
      start2 = 1'b0;
      d = sel ? done2 : done1;
      b = sel ? busy2 : busy1;
      if (b) busy_cycles++;
      if (d) begin
        lat = c;
        bcd = sel ? {4'h0, bcd2} : bcd1;
        ovf = sel ? ovf2 : ovf1;
        break;
      end
    end
    tick();  // DONE -> IDLE
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    start1 = 1'b1; bin1 = 8'd255;   // reset must win over start
    start2 = 1'b0; bin2 = 8'd0;
    tick();
    tick();
    start1 = 1'b0;
    checks++;
    if ({busy1, done1, ovf1, bcd1} !== 15'h0) begin
      errors++;
      $display("FAIL reset_dut: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy1, done1, ovf1, bcd1);
    end
    checks++;
    if ({busy2, done2, ovf2, bcd2} !== 11'h0) begin
      errors++;
      $display("FAIL reset_dut2: busy=%b done=%b ovf=%b bcd=%h, required all zero", busy2, done2, ovf2, bcd2);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_start: busy=%b after reset released, required 0", busy1);
    end
  endtask

  task automatic test_full_scale();
    logic [11:0] bcd; logic ovf; int lat, bc;
    convert(1'b0, 8'd255, bcd, ovf, lat, bc);
    checks++;
    if (bcd !== 12'h255 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL conv_255: bcd=%h ovf=%b, required 255 ovf=0", bcd, ovf);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL latency_255: done at cycle %0d, required 9", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL busy_len_255: busy for %0d cycles, required 8", bc);
    end
    // Result must persist after the DONE cycle.
    checks++;
    if (bcd1 !== 12'h255 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_255: bcd=%h busy=%b done=%b, required 255/0/0", bcd1, busy1, done1);
    end
  endtask

  task automatic test_values();
    logic [7:0]  vin [5]  = '{8'd0,   8'd99,   8'd100,  8'd37,   8'd209};
    logic [11:0] vexp [5] = '{12'h000, 12'h099, 12'h100, 12'h037, 12'h209};
    logic [11:0] bcd; logic ovf; int lat, bc;
    for (int i = 0; i < 5; i++) begin
      convert(1'b0, vin[i], bcd, ovf, lat, bc);
      checks++;
      if (bcd !== vexp[i] || ovf !== 1'b0 || lat !== 9) begin
        errors++;
        $display("FAIL conv_%0d: bcd=%h ovf=%b lat=%0d, required %h ovf=0 lat=9",
                 vin[i], bcd, ovf, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad_busy = 0, bad_done = 0;
    logic [11:0] r9 = '0, r18 = '0;
    logic held_ok = 1'b1;
    start1 = 1'b1; bin1 = 8'd42;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1)  bin1 = 8'd7;     // ignored by the first conversion
      if (c == 10) start1 = 1'b0;   // second conversion already accepted
      if (busy1 !== !(c == 9 || c == 18)) bad_busy++;
      if (done1 !== (c == 9 || c == 18)) bad_done++;
      if (c == 9)  r9 = bcd1;
      if (c == 18) r18 = bcd1;
      if (c >= 10 && c <= 17 && bcd1 !== 12'h042) held_ok = 1'b0;
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL b2b_busy: %0d cycles with wrong busy, required 0", bad_busy);
    end
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL b2b_done: %0d cycles with wrong done, required 0", bad_done);
    end
    checks++;
    if (r9 !== 12'h042 || r18 !== 12'h007) begin
      errors++;
      $display("FAIL b2b_values: got %h then %h, required 042 then 007", r9, r18);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL b2b_hold: result changed during second conversion, required 042 held");
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int ndone = 0, first = -1;
    logic [11:0] r = '0;
    start1 = 1'b1; bin1 = 8'd200;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start1 = (c == 3);
      bin1 = (c == 3) ? 8'd10 : 8'd200;
      if (done1) begin
        ndone++;
        if (first < 0) begin first = c; r = bcd1; end
      end
    end
    start1 = 1'b0;
    checks++;
    if (ndone !== 1 || first !== 9) begin
      errors++;
      $display("FAIL ignore_start_done: %0d pulses first at %0d, required 1 at 9", ndone, first);
    end
    checks++;
    if (r !== 12'h200) begin
      errors++;
      $display("FAIL ignore_start_value: bcd=%h, required 200", r);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    logic [11:0] bcd; logic ovf; int lat, bc;
    // bcd1 holds 200 from the previous test; reset must clear it.
    start1 = 1'b1; bin1 = 8'd77;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start1 = 1'b0;
    end
    rst = 1'b1;   // sampled at the end of cycle 4
    tick();
    rst = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || bcd1 !== 12'h000 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b bcd=%h done=%b, required 0/000/0", busy1, bcd1, done1);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: %0d done pulses, required 0", ndone);
    end
    convert(1'b0, 8'd77, bcd, ovf, lat, bc);
    checks++;
    if (bcd !== 12'h077 || lat !== 9) begin
      errors++;
      $display("FAIL reset_mid_after: bcd=%h lat=%0d, required 077 lat=9", bcd, lat);
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  vin [4]  = '{8'd150, 8'd99, 8'd255, 8'd100};
    logic [11:0] vexp [4] = '{12'h050, 12'h099, 12'h055, 12'h000};
    logic        oexp [4] = '{1'b1,   1'b0,    1'b1,    1'b1};
    logic [11:0] bcd; logic ovf; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      convert(1'b1, vin[i], bcd, ovf, lat, bc);
      checks++;
      if (bcd !== vexp[i] || ovf !== oexp[i] || lat !== 9) begin
        errors++;
        $display("FAIL ovf_conv_%0d: bcd=%h ovf=%b lat=%0d, required %h ovf=%b lat=9",
                 vin[i], bcd, ovf, lat, vexp[i], oexp[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; bin1 = '0; bin2 = '0;
    test_reset();
    test_full_scale();
    test_values();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
